// File: rtl/mem_trace_buffer.sv
// Multi-channel memory-access trace recorder: per-channel hold slots,
// round-robin arbitration into one FWFT FIFO. Optional timestamps: MEM_TRACE_TS_EN.
module mem_trace_buffer #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      enable_i,
    input  logic [NUM_CH-1:0]                         ch_valid_i,
    input  logic [NUM_CH-1:0]                         ch_we_i,
    input  logic [NUM_CH*ADDR_W-1:0]                  ch_addr_i,
    output logic                                      out_valid_o,
    input  logic                                      out_ready_i,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch_o,
    output logic                                      out_we_o,
    output logic [ADDR_W-1:0]                         out_addr_o,
`ifdef MEM_TRACE_TS_EN
    output logic [TS_W-1:0]                           out_ts_o,
`endif
    output logic [$clog2(DEPTH):0]                    count_o,
    output logic                                      overflow_o,
    output logic [15:0]                               drop_cnt_o
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW   = $clog2(DEPTH);

    if (NUM_CH < 1 || NUM_CH > 8 || DEPTH < 2 ||
        (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1) begin : g_param_err
        $error("mem_trace_buffer: illegal parameters");
    end

    logic [NUM_CH-1:0] slot_full;
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] accept;
    logic [NUM_CH-1:0] drop;
    logic              slot_we   [NUM_CH];
    logic [ADDR_W-1:0] slot_addr [NUM_CH];

    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant_idx;
    logic [CH_W:0]     scan;
    logic [CH_W-1:0]   scan_idx;
    logic              grant_any;

    logic              fifo_we   [DEPTH];
    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [CH_W-1:0]   fifo_ch   [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              full;
    logic              pop;
    logic              can_grant;

    logic [3:0]        n_drop;
    logic [16:0]       drop_sum;

`ifdef MEM_TRACE_TS_EN
    logic [TS_W-1:0]   ts_cnt;
    logic [TS_W-1:0]   slot_ts [NUM_CH];
    logic [TS_W-1:0]   fifo_ts [DEPTH];
`endif

    assign out_valid_o = (count_o != '0);
    assign full        = (count_o == (AW+1)'(DEPTH));
    assign pop         = out_valid_o & out_ready_i;
    assign can_grant   = ~full | pop;

    // Round-robin pick of one full slot, scanning from rr_ptr upward.
    always_comb begin
        grant     = '0;
        grant_idx = rr_ptr;
        grant_any = 1'b0;
        scan      = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            scan = {1'b0, rr_ptr} + (CH_W+1)'(i);
            if (scan >= (CH_W+1)'(NUM_CH)) begin
                scan = scan - (CH_W+1)'(NUM_CH);
            end
            scan_idx = scan[CH_W-1:0];
            if (!grant_any && can_grant && slot_full[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                grant_idx       = scan_idx;
                grant_any       = 1'b1;
            end
        end
    end

    // Capture/drop decision per channel and the number of drops this cycle.
    always_comb begin
        accept = '0;
        drop   = '0;
        n_drop = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            accept[c] = enable_i & ch_valid_i[c] & (~slot_full[c] | grant[c]);
            drop[c]   = enable_i & ch_valid_i[c] & slot_full[c] & ~grant[c];
            n_drop    = n_drop + 4'(drop[c]);
        end
        drop_sum = {1'b0, drop_cnt_o} + 17'(n_drop);
    end

    // Hold slots: a granted slot may be refilled at the same edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            slot_full <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                slot_we[c]   <= 1'b0;
                slot_addr[c] <= '0;
`ifdef MEM_TRACE_TS_EN
                slot_ts[c]   <= '0;
`endif
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (accept[c]) begin
                    slot_full[c] <= 1'b1;
                    slot_we[c]   <= ch_we_i[c];
                    slot_addr[c] <= ch_addr_i[c*ADDR_W +: ADDR_W];
`ifdef MEM_TRACE_TS_EN
                    slot_ts[c]   <= ts_cnt;
`endif
                end else if (grant[c]) begin
                    slot_full[c] <= 1'b0;
                end
            end
        end
    end

    // Arbiter pointer advances past the channel just granted.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            if (int'(grant_idx) == NUM_CH - 1) rr_ptr <= '0;
            else                               rr_ptr <= grant_idx + 1'b1;
        end
    end

    // FIFO storage; contents are don't-care until counted in.
    always_ff @(posedge clk_i) begin
        if (grant_any) begin
            fifo_we[wr_ptr]   <= slot_we[grant_idx];
            fifo_addr[wr_ptr] <= slot_addr[grant_idx];
            fifo_ch[wr_ptr]   <= grant_idx;
`ifdef MEM_TRACE_TS_EN
            fifo_ts[wr_ptr]   <= slot_ts[grant_idx];
`endif
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (grant_any) wr_ptr <= wr_ptr + 1'b1;
            if (pop)       rd_ptr <= rd_ptr + 1'b1;
            if (grant_any && !pop)      count_o <= count_o + 1'b1;
            else if (!grant_any && pop) count_o <= count_o - 1'b1;
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (|drop) begin
            overflow_o <= 1'b1;
            drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

`ifdef MEM_TRACE_TS_EN
    // Free-running timestamp, wraps naturally.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) ts_cnt <= '0;
        else        ts_cnt <= ts_cnt + 1'b1;
    end

    assign out_ts_o = out_valid_o ? fifo_ts[rd_ptr] : '0;
`endif

    assign out_ch_o   = out_valid_o ? fifo_ch[rd_ptr]   : '0;
    assign out_we_o   = out_valid_o ? fifo_we[rd_ptr]   : 1'b0;
    assign out_addr_o = out_valid_o ? fifo_addr[rd_ptr] : '0;

endmodule
